fp_wb_arbiter: RTL and testbench
================================

Name: fp_wb_arbiter

Overview:
- Write-side controller for the 32-entry floating-point register file.
- Collects results from three producers over valid/ready handshakes:
  - src0: single-cycle FP ALU
  - src1: multi-cycle FP div/sqrt
  - src2: FLW load return
- Grants one producer per cycle using round-robin arbitration and drives the register file's single write port (wa/wd/we) from a register stage.
- Maintains a 32-bit pending-write scoreboard that issue logic uses to stall RAW/WAW hazards.

Parameters:
- ADDR_W, 5, register address width (32 FP registers).
- DATA_W, 32, result/register data width (single precision).
- CNT_W, 16, width of the write-count debug counter.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rstn  in  1  reset, asynchronous, active-low.
- s_valid  in  3  per-source result valid; bit i = source i.
- s_ready  out  3  per-source grant; combinational, at most one bit high.
- s_addr  in  3*ADDR_W  destination register per source; source i at bits [5i+4:5i].
- s_data  in  3*DATA_W  result data per source; source i at bits [32i+31:32i].
- alloc_valid  in  1  issue stage marks a register as having an outstanding write.
- alloc_addr  in  ADDR_W  register being allocated.
- we  out  1  register file write enable.
- wa  out  ADDR_W  register file write address.
- wd  out  DATA_W  register file write data.
- busy  out  32  pending-write bitmap; bit r = fr has an outstanding write.
- wb_count  out  CNT_W  number of register file writes performed.

Behaviour:
- Reset (rstn=0, asynchronous) clears state immediately:
  - we=0, wa=0, wd=0, busy=0, wb_count=0.
  - Round-robin pointer rr=0.
  - s_ready=0 for as long as rstn=0.
- Handshake:
  - Source i transfers on a cycle with s_valid[i]=1 and s_ready[i]=1.
  - A source holds s_valid, s_addr and s_data stable until the transfer.
  - s_ready[i] depends only on s_valid and rr; it never depends on s_ready itself.
- Arbitration:
  - Candidate order is rr, rr+1, rr+2 (mod 3).
  - The first candidate with s_valid=1 is granted.
  - After a grant to source g, rr <= (g+1) mod 3.
  - With no valid source, rr holds.
  - One grant per cycle; the write port is never stalled, so a valid source is granted within 3 cycles (starvation-free).
- Output stage:
  - On the edge that completes a transfer: we<=1, wa<=granted addr, wd<=granted data.
  - Otherwise we<=0; wa and wd hold their last values.
  - Latency from handshake to the register file write edge is exactly 1 cycle.
  - Back-to-back grants produce a write every cycle.
- Register file contract:
  - The register file is write-first with same-cycle bypass, so consumers see wd in the cycle we=1.
  - f0 is an ordinary register; writes to address 0 are performed normally.
- Scoreboard, evaluated at each edge for every bit r:
  - set_r = alloc_valid && alloc_addr==r.
  - clr_r = we && wa==r (uses the registered output, i.e. the write occurring this cycle).
  - busy[r] <= set_r ? 1 : (clr_r ? 0 : busy[r]).
  - Simultaneous set and clear of the same r: set wins, because a new op has been issued.
  - Issue logic never allocates a register whose busy bit is already 1. Such an alloc is illegal; the bit simply stays 1.
  - A write to a register with busy=0 (e.g. a boot-time load) is legal and leaves the bit 0.
- wb_count:
  - Increments by 1 on every cycle with we=1.
  - Wraps from 2^CNT_W-1 to 0.
- Reset mid-operation:
  - A result granted in the cycle reset asserts is lost.
  - Producers must re-issue after reset; the block makes no recovery attempt.

Test Plan:
- Reset: assert rstn=0 mid-cycle with we=1 -> we, busy and wb_count read 0 immediately, before the next clk edge; after release, s_ready=0 until some s_valid=1.
- Single transfer: src1 valid, addr=7, data=0x3F800000 -> s_ready=3'b010 that cycle; next cycle we=1, wa=7, wd=0x3F800000; the following cycle we=0; wb_count=1.
- Round-robin fairness: all three sources hold valid continuously with addrs 1, 2, 3 (rr=0 after reset) -> grants in order src0, src1, src2, src0...; wa sequence 1, 2, 3, 1 on consecutive cycles; no source waits more than 2 cycles.
- Scoreboard set/clear: alloc fr5 -> busy[5]=1 next cycle; src2 delivers addr 5 -> busy[5] clears on the edge where we=1, wa=5. Separately, alloc fr9 in the same cycle as a write to fr9 -> busy[9] stays 1.
- f0 and wrap: write addr 0 with data 0xDEADBEEF -> we=1, wa=0, wd=0xDEADBEEF. Preload wb_count to 0xFFFF via 65535 writes, then one more write -> wb_count=0x0000.
- Hold protocol: src1 valid while src0 is granted (rr=0) -> src1 keeps its data stable and is granted the next cycle with the correct wd; no duplicate write is observed.

Source files
------------

// File: rtl/fp_wb_arbiter.sv
// FP register file write-back arbiter.
// Round-robin over ALU, div/sqrt and FLW results; tracks pending writes.
module fp_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [2:0]            s_valid,
  output logic [2:0]            s_ready,
  input  logic [3*ADDR_W-1:0]   s_addr,
  input  logic [3*DATA_W-1:0]   s_data,
  input  logic                  alloc_valid,
  input  logic [ADDR_W-1:0]     alloc_addr,
  output logic                  we,
  output logic [ADDR_W-1:0]     wa,
  output logic [DATA_W-1:0]     wd,
  output logic [(1<<ADDR_W)-1:0] busy,
  output logic [CNT_W-1:0]      wb_count
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    RR0 = 2'd0,
    RR1 = 2'd1,
    RR2 = 2'd2
  } rr_e;

  rr_e               rr_q;
  rr_e               rr_d;
  logic [2:0]        gnt;
  logic              xfer;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic [NREG-1:0]   set_vec;
  logic [NREG-1:0]   clr_vec;
  logic [NREG-1:0]   busy_d;

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rr_q <= RR0;
    else       rr_q <= rr_d;
  end

  // Priority search starting at rr; pointer moves past the winner
  always_comb begin
    gnt  = 3'b000;
    rr_d = rr_q;
    unique case (rr_q)
      RR0: begin
        if      (s_valid[0]) gnt = 3'b001;
        else if (s_valid[1]) gnt = 3'b010;
        else if (s_valid[2]) gnt = 3'b100;
      end
      RR1: begin
        if      (s_valid[1]) gnt = 3'b010;
        else if (s_valid[2]) gnt = 3'b100;
        else if (s_valid[0]) gnt = 3'b001;
      end
      RR2: begin
        if      (s_valid[2]) gnt = 3'b100;
        else if (s_valid[0]) gnt = 3'b001;
        else if (s_valid[1]) gnt = 3'b010;
      end
      default: gnt = 3'b000;
    endcase
    unique case (1'b1)
      gnt[0]:  rr_d = RR1;
      gnt[1]:  rr_d = RR2;
      gnt[2]:  rr_d = RR0;
      default: rr_d = rr_q;
    endcase
  end

  assign s_ready = rstn ? gnt : 3'b000;
  assign xfer    = |s_ready;

  // Select the granted source's address and data
  always_comb begin
    g_addr = '0;
    g_data = '0;
    unique case (1'b1)
      s_ready[0]: begin
        g_addr = s_addr[0*ADDR_W +: ADDR_W];
        g_data = s_data[0*DATA_W +: DATA_W];
      end
      s_ready[1]: begin
        g_addr = s_addr[1*ADDR_W +: ADDR_W];
        g_data = s_data[1*DATA_W +: DATA_W];
      end
      s_ready[2]: begin
        g_addr = s_addr[2*ADDR_W +: ADDR_W];
        g_data = s_data[2*DATA_W +: DATA_W];
      end
      default: begin
        g_addr = '0;
        g_data = '0;
      end
    endcase
  end

  // Write port register stage; address/data hold when idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we <= 1'b0;
      wa <= '0;
      wd <= '0;
    end else begin
      we <= xfer;
      if (xfer) begin
        wa <= g_addr;
        wd <= g_data;
      end
    end
  end

  // Pending-write bitmap next state; a new alloc beats a retiring write
  always_comb begin
    set_vec = alloc_valid ? (NREG'(1) << alloc_addr) : '0;
    clr_vec = we ? (NREG'(1) << wa) : '0;
    busy_d  = (busy & ~clr_vec) | set_vec;
  end

  // Scoreboard and write counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= '0;
      wb_count <= '0;
    end else begin
      busy     <= busy_d;
      wb_count <= wb_count + CNT_W'(we);
    end
  end

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Bench for fp_wb_arbiter.
// Expected writes go into a queue; a negedge monitor pops them.
module tb_fp_wb_arbiter;

  logic        clk;
  logic        rstn;
  logic [2:0]  s_valid;
  logic [2:0]  s_ready;
  logic [14:0] s_addr;
  logic [95:0] s_data;
  logic        alloc_valid;
  logic [4:0]  alloc_addr;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [31:0] busy;
  logic [15:0] wb_count;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  fp_wb_arbiter #(.ADDR_W(5), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
    .we(we), .wa(wa), .wd(wd),
    .busy(busy), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic src(input int i, input logic v,
                     input logic [4:0] a, input logic [31:0] d);
    s_valid[i] = v;
    s_addr[i*5 +: 5] = a;
    s_data[i*32 +: 32] = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    #4 rstn = 1'b1;
    cyc();
  endtask

  // Scoreboard monitor: every write must match the oldest expectation
  always @(negedge clk) begin
    if (we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got wa=%0d wd=%h want none", wa, wd);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("write", 64'({wa, wd}), 64'(e));
      end
    end
  end

  initial begin
    rstn = 1'b0;
    s_valid = '0;
    s_addr = '0;
    s_data = '0;
    alloc_valid = 1'b0;
    alloc_addr = '0;

    // Reset state
    @(negedge clk);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cnt", 64'(wb_count), 64'd0);
    s_valid = 3'b001;
    #1 chk("rst_ready_gated", 64'(s_ready), 64'd0);
    s_valid = 3'b000;
    #2 rstn = 1'b1;
    cyc();
    @(negedge clk);
    chk("idle_ready", 64'(s_ready), 64'd0);
    cyc();

    // Single transfer from src1
    src(1, 1'b1, 5'd7, 32'h3F800000);
    expect_wr(5'd7, 32'h3F800000);
    @(negedge clk);
    chk("single_ready", 64'(s_ready), 64'b010);
    cyc();
    src(1, 1'b0, 5'd7, 32'h3F800000);
    @(negedge clk);
    chk("single_we", 64'(we), 64'd1);
    cyc();
    @(negedge clk);
    chk("single_we_off", 64'(we), 64'd0);
    chk("single_cnt", 64'(wb_count), 64'd1);

    // Round-robin with all three sources valid
    do_reset();
    src(0, 1'b1, 5'd1, 32'hAAAA0001);
    src(1, 1'b1, 5'd2, 32'hBBBB0002);
    src(2, 1'b1, 5'd3, 32'hCCCC0003);
    expect_wr(5'd1, 32'hAAAA0001);
    expect_wr(5'd2, 32'hBBBB0002);
    expect_wr(5'd3, 32'hCCCC0003);
    expect_wr(5'd1, 32'hAAAA0001);
    @(negedge clk); chk("rr_g0", 64'(s_ready), 64'b001); cyc();
    @(negedge clk); chk("rr_g1", 64'(s_ready), 64'b010); cyc();
    @(negedge clk); chk("rr_g2", 64'(s_ready), 64'b100); cyc();
    @(negedge clk); chk("rr_g3", 64'(s_ready), 64'b001); cyc();
    s_valid = 3'b000;
    @(negedge clk); chk("rr_we_b2b", 64'(we), 64'd1); cyc();

    // Hold protocol: src1 waits one cycle behind src0
    do_reset();
    src(0, 1'b1, 5'd4, 32'h11111111);
    src(1, 1'b1, 5'd6, 32'h22222222);
    expect_wr(5'd4, 32'h11111111);
    expect_wr(5'd6, 32'h22222222);
    @(negedge clk); chk("hold_g0", 64'(s_ready), 64'b001); cyc();
    s_valid[0] = 1'b0;
    @(negedge clk); chk("hold_g1", 64'(s_ready), 64'b010); cyc();
    s_valid[1] = 1'b0;
    @(negedge clk); chk("hold_idle", 64'(s_ready), 64'b000); cyc();

    // Scoreboard set then clear by src2
    alloc_valid = 1'b1;
    alloc_addr = 5'd5;
    cyc();
    alloc_valid = 1'b0;
    @(negedge clk); chk("busy5_set", 64'(busy), 64'h20);
    src(2, 1'b1, 5'd5, 32'h40490FDB);
    expect_wr(5'd5, 32'h40490FDB);
    #1 chk("busy5_ready", 64'(s_ready), 64'b100);
    cyc();
    s_valid = 3'b000;
    @(negedge clk); chk("busy5_during_we", 64'(busy), 64'h20);
    cyc();
    @(negedge clk); chk("busy5_clr", 64'(busy), 64'h0);

    // Write to idle fr9, alloc fr9 in the write cycle: set wins
    cyc();
    src(0, 1'b1, 5'd9, 32'h12345678);
    expect_wr(5'd9, 32'h12345678);
    cyc();
    s_valid = 3'b000;
    alloc_valid = 1'b1;
    alloc_addr = 5'd9;
    @(negedge clk); chk("busy9_idle_write", 64'(busy), 64'h0);
    cyc();
    alloc_valid = 1'b0;
    @(negedge clk); chk("busy9_set_wins", 64'(busy), 64'h200);

    // Asynchronous reset while we=1
    cyc();
    src(0, 1'b1, 5'd10, 32'h55AA55AA);
    expect_wr(5'd10, 32'h55AA55AA);
    cyc();
    s_valid = 3'b000;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_we", 64'(we), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cnt", 64'(wb_count), 64'd0);
    #2 rstn = 1'b1;
    cyc();

    // Counter wrap, ending with a write to f0
    do_reset();
    src(0, 1'b1, 5'd3, 32'h00001234);
    repeat (65535) begin
      expect_wr(5'd3, 32'h00001234);
      cyc();
    end
    src(0, 1'b1, 5'd0, 32'hDEADBEEF);
    expect_wr(5'd0, 32'hDEADBEEF);
    cyc();
    s_valid = 3'b000;
    @(negedge clk);
    chk("f0_wa", 64'(wa), 64'd0);
    chk("f0_wd", 64'(wd), 64'hDEADBEEF);
    chk("cnt_max", 64'(wb_count), 64'hFFFF);
    cyc();
    @(negedge clk);
    chk("cnt_wrap", 64'(wb_count), 64'h0);
    chk("wrap_we_off", 64'(we), 64'd0);

    repeat (2) cyc();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
